// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the instruction datapath
// (port 0) and the address generator (port 1).
module alu_arbiter #(
    parameter int W  = 19,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [3:0]    req0_op,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [3:0]    req1_op,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    output logic [3:0]    alu_op,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_z,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_z,
    output logic          rsp_err,
    output logic          busy,
    output logic [CW-1:0] op_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]    r_state;
    logic          r_prio;
    logic          r_id;
    logic [3:0]    r_op;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_rsp0_valid;
    logic          r_rsp1_valid;
    logic [W-1:0]  r_rsp_data;
    logic          r_rsp_z;
    logic          r_rsp_err;
    logic [CW-1:0] r_op_count;

    logic w_idle;
    logic w_win0;
    logic w_win1;
    logic w_accept;
    logic w_illegal;
    logic w_sub;
    logic w_drive;

    assign w_idle   = (r_state == S_IDLE) && !RST;
    // Port 1 wins when alone or when favoured; port 0 takes everything else.
    assign w_win1   = req1_valid && (!req0_valid || r_prio);
    assign w_win0   = req0_valid && !w_win1;
    assign req0_ready = w_idle && w_win0;
    assign req1_ready = w_idle && w_win1;
    assign w_accept = req0_ready || req1_ready;

    assign w_illegal = r_op[3];
    assign w_sub     = (r_op == 4'd2) || (r_op == 4'd4);
    assign w_drive   = ((r_state == S_ISSUE) || (r_state == S_CAPTURE))
                       && !w_illegal;

    assign alu_op = w_drive ? r_op : '0;
    assign alu_a  = w_drive ? r_a  : '0;
    assign alu_b  = w_drive ? r_b  : '0;

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_z      = r_rsp_z;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != S_IDLE);
    assign op_count   = r_op_count;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_id         <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_z      <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= req1_ready ? req1_op : req0_op;
                        r_a     <= req1_ready ? req1_a  : req0_a;
                        r_b     <= req1_ready ? req1_b  : req0_b;
                        r_id    <= req1_ready;
                        r_prio  <= !req1_ready;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // The ALU flag is only meaningful after a subtract.
                    r_rsp_data   <= w_illegal ? '0 : alu_result;
                    r_rsp_z      <= w_sub && alu_z;
                    r_rsp_err    <= w_illegal;
                    r_rsp0_valid <= !r_id;
                    r_rsp1_valid <= r_id;
                    r_op_count   <= r_op_count + CW'(1);
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with an ALU stub.
module tb_alu_arbiter;

    localparam int W  = 19;
    localparam int CW = 10;
    localparam int DW = 4 + 2 * W;

    typedef struct {
        int           due;
        logic         id;
        logic [W-1:0] data;
        logic         z;
        logic         err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          RST;
    logic          req0_valid, req0_ready;
    logic [3:0]    req0_op;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready;
    logic [3:0]    req1_op;
    logic [W-1:0]  req1_a, req1_b;
    logic [3:0]    alu_op;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic          alu_z = 1'b0;
    logic          rsp0_valid, rsp1_valid;
    logic [W-1:0]  rsp_data;
    logic          rsp_z, rsp_err, busy;
    logic [CW-1:0] op_count;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.W(W), .CW(CW)) dut (
        .clk(clk), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_z(alu_z),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    function automatic logic [W-1:0] alu_fn(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            4'd0: return a + W'(1);
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a + b;
            4'd4: return a - b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return a | b;
            default: return '0;
        endcase
    endfunction

    // ALU stub: combinational result, zero flag registered one cycle later
    assign alu_result = alu_fn(alu_op, alu_a, alu_b);
    always @(posedge clk) alu_z <= (alu_result == '0);

    wire [4:0]      ctl_got = {req0_ready, req1_ready, busy,
                               rsp0_valid, rsp1_valid};
    wire [DW-1:0]   alu_got = {alu_op, alu_a, alu_b};
    wire [W+1:0]    rsp_got = {rsp_data, rsp_z, rsp_err};

    task automatic idle_in();
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    endtask

    task automatic drive0(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST = 1; idle_in();
        @(negedge clk);
        RST = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        RST = 1;
        drive0(4'd1, 19'd1, 19'd2);
        drive1(4'd1, 19'd3, 19'd4);
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
        end
        @(negedge clk);
        #1;
        vectors++;
        if (ctl_got !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctl got=%b exp=00000", ctl_got);
        end
        vectors++;
        if (alu_got !== '0) begin
            miscompares++;
            $display("FAIL reset_alu got=%h exp=0", alu_got);
        end
        vectors++;
        if (rsp_got !== '0 || op_count !== '0) begin
            miscompares++;
            $display("FAIL reset_rsp got=%h/%h exp=0/0", rsp_got, op_count);
        end
        RST = 0;
        idle_in();
    endtask

    task automatic test_port0();
        logic [4:0]    e_ctl;
        logic [DW-1:0] e_alu;
        do_reset();
        drive0(4'd1, 19'd100, 19'd23);
        #1;
        vectors++;
        if (ctl_got !== 5'b10000) begin
            miscompares++;
            $display("FAIL p0_accept got=%b exp=10000", ctl_got);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) idle_in();
            #1;
            e_ctl = {2'b00, k < 3, k == 3, 1'b0};
            e_alu = (k < 3) ? {4'd1, 19'd100, 19'd23} : '0;
            vectors++;
            if (ctl_got !== e_ctl) begin
                miscompares++;
                $display("FAIL p0_ctl[%0d] got=%b exp=%b", k, ctl_got, e_ctl);
            end
            vectors++;
            if (alu_got !== e_alu) begin
                miscompares++;
                $display("FAIL p0_alu[%0d] got=%h exp=%h", k, alu_got, e_alu);
            end
            if (k >= 3) begin
                vectors++;
                if (rsp_got !== {19'd123, 2'b00} || op_count !== CW'(1)) begin
                    miscompares++;
                    $display("FAIL p0_rsp[%0d] got=%h/%0d exp=%h/1",
                             k, rsp_got, op_count, {19'd123, 2'b00});
                end
            end
        end
    endtask

    task automatic test_port1();
        logic [3:0]   ops [3] = '{4'd4, 4'd0, 4'd7};
        logic [W-1:0] as  [3] = '{19'h7FFFF, 19'd5, 19'd0};
        logic [W-1:0] bs  [3] = '{19'h7FFFF, 19'd0, 19'd0};
        logic [W+1:0] ers [3] = '{{19'd0, 2'b10}, {19'd6, 2'b00},
                                  {19'd0, 2'b00}};
        logic [4:0]    e_ctl;
        logic [DW-1:0] e_alu;
        int            k;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            k = c / 3;
            if (c % 3 == 0 && c < 9) drive1(ops[k], as[k], bs[k]);
            else idle_in();
            #1;
            e_ctl = {1'b0, c % 3 == 0 && c < 9, c % 3 != 0,
                     1'b0, c % 3 == 0 && c > 0};
            e_alu = (c % 3 != 0) ? {ops[k], as[k], bs[k]} : '0;
            vectors++;
            if (ctl_got !== e_ctl) begin
                miscompares++;
                $display("FAIL p1_ctl[%0d] got=%b exp=%b", c, ctl_got, e_ctl);
            end
            vectors++;
            if (alu_got !== e_alu) begin
                miscompares++;
                $display("FAIL p1_alu[%0d] got=%h exp=%h", c, alu_got, e_alu);
            end
            if (c % 3 == 0 && c > 0) begin
                vectors++;
                if (rsp_got !== ers[k-1] || op_count !== CW'(k)) begin
                    miscompares++;
                    $display("FAIL p1_rsp[%0d] got=%h/%0d exp=%h/%0d",
                             c, rsp_got, op_count, ers[k-1], k);
                end
            end
        end
    endtask

    task automatic test_alternate();
        logic [4:0]    e_ctl;
        logic [W-1:0]  e_data;
        int            n0 = 0, n1 = 0, g, r;
        do_reset();
        for (int c = 0; c < 27; c++) begin
            if (c > 0) @(negedge clk);
            idle_in();
            if (n0 < 4) drive0(4'd1, W'(10 * n0 + 1), W'(n0));
            if (n1 < 4) drive1(4'd3, W'(500 + n1), 19'd7);
            #1;
            g = c / 3;
            r = g - 1;
            e_ctl = {c % 3 == 0 && g < 8 && g % 2 == 0,
                     c % 3 == 0 && g < 8 && g % 2 == 1,
                     c % 3 != 0 && c < 24,
                     c % 3 == 0 && c > 0 && r % 2 == 0,
                     c % 3 == 0 && c > 0 && r % 2 == 1};
            vectors++;
            if (ctl_got !== e_ctl) begin
                miscompares++;
                $display("FAIL alt_ctl[%0d] got=%b exp=%b", c, ctl_got, e_ctl);
            end
            if (c % 3 == 0 && c > 0) begin
                e_data = (r % 2 == 0) ? alu_fn(4'd1, W'(10 * (r / 2) + 1), W'(r / 2))
                                      : alu_fn(4'd3, W'(500 + r / 2), 19'd7);
                vectors++;
                if (rsp_got !== {e_data, 2'b00} || op_count !== CW'(g)) begin
                    miscompares++;
                    $display("FAIL alt_rsp[%0d] got=%h/%0d exp=%h/%0d",
                             c, rsp_got, op_count, {e_data, 2'b00}, g);
                end
            end
            if (c % 3 == 0 && g < 8) begin
                if (g % 2 == 0) n0++;
                else n1++;
            end
        end
        idle_in();
    endtask

    task automatic test_illegal();
        logic [3:0]   ops [3] = '{4'd1, 4'd12, 4'd2};
        logic [W-1:0] as  [3] = '{19'd100, 19'd5, 19'd9};
        logic [W-1:0] bs  [3] = '{19'd23, 19'd9, 19'd9};
        logic [W+1:0] ers [3] = '{{19'd123, 2'b00}, {19'd0, 2'b01},
                                  {19'd0, 2'b10}};
        logic [4:0]    e_ctl;
        logic [DW-1:0] e_alu;
        int            k;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            k = c / 3;
            if (c % 3 == 0 && c < 9) drive0(ops[k], as[k], bs[k]);
            else idle_in();
            #1;
            e_ctl = {c % 3 == 0 && c < 9, 1'b0, c % 3 != 0,
                     c % 3 == 0 && c > 0, 1'b0};
            e_alu = (c % 3 != 0 && !ops[k][3]) ? {ops[k], as[k], bs[k]} : '0;
            vectors++;
            if (ctl_got !== e_ctl) begin
                miscompares++;
                $display("FAIL ill_ctl[%0d] got=%b exp=%b", c, ctl_got, e_ctl);
            end
            vectors++;
            if (alu_got !== e_alu) begin
                miscompares++;
                $display("FAIL ill_alu[%0d] got=%h exp=%h", c, alu_got, e_alu);
            end
            if (c % 3 == 0 && c > 0) begin
                vectors++;
                if (rsp_got !== ers[k-1] || op_count !== CW'(k)) begin
                    miscompares++;
                    $display("FAIL ill_rsp[%0d] got=%h/%0d exp=%h/%0d",
                             c, rsp_got, op_count, ers[k-1], k);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            idle_in();
            if (c == 0) drive0(4'd1, 19'd100, 19'd23);
            if (c == 3) drive0(4'd5, 19'd1, 19'd3);
            if (c == 5) RST = 1;
            if (c == 6) RST = 0;
            if (c == 7) begin
                drive0(4'd1, 19'd1, 19'd1);
                drive1(4'd1, 19'd2, 19'd2);
            end
            #1;
            if (c == 3) begin
                vectors++;
                if (ctl_got !== 5'b10010 || op_count !== CW'(1)) begin
                    miscompares++;
                    $display("FAIL abort_pre got=%b/%0d exp=10010/1",
                             ctl_got, op_count);
                end
            end
            if (c == 5) begin
                vectors++;
                if (alu_got !== {4'd5, 19'd1, 19'd3}) begin
                    miscompares++;
                    $display("FAIL abort_cap_alu got=%h exp=%h",
                             alu_got, {4'd5, 19'd1, 19'd3});
                end
            end
            if (c == 6) begin
                vectors++;
                if (ctl_got !== 5'b0 || alu_got !== '0) begin
                    miscompares++;
                    $display("FAIL abort_ctl got=%b/%h exp=00000/0",
                             ctl_got, alu_got);
                end
                vectors++;
                if (rsp_got !== '0 || op_count !== '0) begin
                    miscompares++;
                    $display("FAIL abort_rsp got=%h/%0d exp=0/0",
                             rsp_got, op_count);
                end
            end
            if (c == 7) begin
                vectors++;
                if (ctl_got !== 5'b10000) begin
                    miscompares++;
                    $display("FAIL abort_prio got=%b exp=10000", ctl_got);
                end
            end
        end
        idle_in();
    endtask

    task automatic test_random(input int n);
        rsp_t          q[$];
        rsp_t          e;
        logic          m_prio = 0;
        int            m_left = 0;
        logic [DW-1:0] m_drv = '0;
        logic [W+1:0]  m_rsp = '0;
        logic [CW-1:0] m_cnt = '0;
        logic          v [2] = '{0, 0};
        logic          acc [2] = '{0, 0};
        logic [3:0]    op [2];
        logic [W-1:0]  a [2], b [2];
        logic [1:0]    rdy, rv;
        logic          m_busy;
        int            w;
        do_reset();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!v[p] || acc[p] || $urandom_range(0, 7) == 0) begin
                    v[p]  = 1'($urandom_range(0, 1));
                    op[p] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15))
                                                        : 4'($urandom_range(0, 7));
                    b[p]  = $urandom_range(0, 1) ? W'($urandom_range(0, 20))
                                                 : W'($urandom);
                    a[p]  = ($urandom_range(0, 3) == 0) ? b[p] : W'($urandom);
                end
            end
            req0_valid = v[0]; req0_op = op[0]; req0_a = a[0]; req0_b = b[0];
            req1_valid = v[1]; req1_op = op[1]; req1_a = a[1]; req1_b = b[1];
            #1;
            m_busy = (m_left > 0);
            rdy = 2'b00;
            w = (v[0] && v[1]) ? int'(m_prio) : (v[1] ? 1 : 0);
            if (!m_busy && (v[0] || v[1])) rdy[w] = 1'b1;
            rv = 2'b00;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                rv[e.id] = 1'b1;
                m_rsp = {e.data, e.z, e.err};
                m_cnt = m_cnt + CW'(1);
            end
            vectors++;
            if (ctl_got !== {rdy[0], rdy[1], m_busy, rv[0], rv[1]}) begin
                miscompares++;
                $display("FAIL rnd_ctl[%0d] got=%b exp=%b", i, ctl_got,
                         {rdy[0], rdy[1], m_busy, rv[0], rv[1]});
            end
            vectors++;
            if (alu_got !== (m_busy ? m_drv : '0)) begin
                miscompares++;
                $display("FAIL rnd_alu[%0d] got=%h exp=%h", i, alu_got,
                         m_busy ? m_drv : '0);
            end
            vectors++;
            if (rsp_got !== m_rsp || op_count !== m_cnt) begin
                miscompares++;
                $display("FAIL rnd_rsp[%0d] got=%h/%0d exp=%h/%0d", i,
                         rsp_got, op_count, m_rsp, m_cnt);
            end
            acc[0] = rdy[0];
            acc[1] = rdy[1];
            if (m_busy) begin
                m_left--;
            end else if (rdy != 2'b00) begin
                m_left = 2;
                e.due  = cyc + 3;
                e.id   = w[0];
                e.err  = op[w][3];
                e.data = op[w][3] ? '0 : alu_fn(op[w], a[w], b[w]);
                e.z    = (op[w] == 4'd2 || op[w] == 4'd4) && e.data == '0;
                m_drv  = op[w][3] ? '0 : {op[w], a[w], b[w]};
                m_prio = ~w[0];
                q.push_back(e);
            end
        end
        idle_in();
    endtask

    task automatic test_wrap();
        int nrsp = 1 << CW;
        do_reset();
        drive0(4'd0, 19'd3, 19'd0);
        for (int c = 0; c <= 3 * nrsp; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c % 3 == 0 && c > 0) begin
                vectors++;
                if (rsp0_valid !== 1'b1 || op_count !== CW'(c / 3)) begin
                    miscompares++;
                    $display("FAIL wrap[%0d] got=%b/%0d exp=1/%0d", c / 3,
                             rsp0_valid, op_count, CW'(c / 3));
                end
            end
        end
        idle_in();
    endtask

    initial begin
        RST = 1;
        idle_in();
        test_reset();
        test_port0();
        test_port1();
        test_alternate();
        test_illegal();
        test_reset_abort();
        test_random(800);
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 19-bit ALU of the downsampling processor between two requesters: port 0, the instruction datapath, and port 1, the address generator. It accepts operation requests over a valid/ready handshake and arbitrates round-robin. It drives the ALU's opcode and operand inputs, waits for the registered zero flag, and returns result, zero flag and error status to the winning requester as a one-cycle response pulse.

## Interface
- W, 19, operand and result width; must match the ALU datapath width.
- CW, 16, width of the completed-operation counter.

- clk  in  1  system clock; all state updates on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- req0_valid / req1_valid  in  1  requester N has an operation pending.
- req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle.
- req0_op / req1_op  in  4  opcode: 0 INCR, 1 ADDI, 2 SUBI, 3 ADDR, 4 SUBR, 5 SHL, 6 SHR, 7 OR; 8–15 are illegal.
- req0_a, req0_b / req1_a, req1_b  in  W  operands.
- alu_op  out  4  opcode to the ALU.
- alu_a, alu_b  out  W  operands to the ALU.
- alu_result  in  W  combinational ALU result.
- alu_z  in  1  zero flag, registered inside the ALU (one cycle after the operands).
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse to requester N.
- rsp_data  out  W  result; shared by both ports.
- rsp_z  out  1  zero flag; shared by both ports.
- rsp_err  out  1  set when the opcode was illegal; shared by both ports.
- busy  out  1  high whenever the state is not IDLE.
- op_count  out  CW  number of completed responses; wraps.

## Operation
- States: IDLE → ISSUE → CAPTURE → IDLE.
- Arbitration happens in IDLE.
  - Pointer `prio` (reset 0) marks the favoured port.
  - If both ports are valid, the favoured port wins. If only one is valid, that port wins.
  - `reqN_ready` is combinational. It is high only in IDLE, only for the winner, and only when that port's valid is high.
- Acceptance occurs when `reqN_valid & reqN_ready`. On acceptance the block:
  - latches op, a, b and the port id;
  - sets `prio` to the port that did not win;
  - moves to ISSUE.
- The block does not back-pressure responses. Requesters must sink a response in the cycle it appears.
- ISSUE: `alu_op/alu_a/alu_b` are driven from the latched values. The next state is CAPTURE.
- CAPTURE: the operand drive is held unchanged, so `alu_result` stays stable. On the clock edge the block:
  - registers `rsp_data ← alu_result`;
  - registers `rsp_z ← alu_z` for op 2 or 4, and 0 for every other op (the ALU flag is stale for non-subtract ops);
  - asserts `rsp<id>_valid` for the next cycle;
  - increments `op_count`, wrapping from 2^CW−1 to 0;
  - moves to IDLE.
- Illegal opcode (8–15): the request follows the same state sequence and latency. `alu_op/alu_a/alu_b` stay at 0 throughout. The response carries `rsp_data=0`, `rsp_z=0`, `rsp_err=1`, and `op_count` still increments.
- Outside ISSUE and CAPTURE, `alu_op`, `alu_a` and `alu_b` are driven to 0.
- `rsp_data`, `rsp_z` and `rsp_err` hold their values until the next response.

## Timing
- Reset values (the cycle after RST is sampled high):
  - state IDLE, `prio`=0;
  - `req*_ready`=0 while RST is high;
  - `alu_op`=0, `alu_a`=0, `alu_b`=0;
  - `rsp0_valid`=0, `rsp1_valid`=0, `rsp_data`=0, `rsp_z`=0, `rsp_err`=0;
  - `busy`=0, `op_count`=0.
- Cycle-level sequence:
  - Accept in cycle T.
  - ALU is driven in cycles T+1 and T+2.
  - `rspN_valid` is high in cycle T+3 only.
  - Throughput: the next request can be accepted in cycle T+3. A request and the previous response can coincide in that cycle.
- `busy` is high in T+1 and T+2.
- Reset during ISSUE or CAPTURE aborts the operation: no response is produced and the ALU drive returns to 0.
- A requester must hold valid and payload stable until ready. Dropping valid before ready is legal; that request is simply lost.

## Test plan
- Port 0 only, op=1, a=100, b=23, accepted in cycle 0 → `rsp0_valid` pulses only in cycle 3 with `rsp_data`=123, `rsp_z`=0, `rsp_err`=0, and `op_count`=1.
- Port 1, op=4, a=b=0x7FFFF → `rsp1_valid` with `rsp_data`=0 and `rsp_z`=1. Follow with op=0, a=5 → `rsp_data`=6 and `rsp_z`=0.
- Both ports valid continuously, 4 ops each, after reset → grants alternate 0,1,0,1,… one every 3 cycles, and each `rspN_valid` matches its port's order.
- Port 0 op=12 → response at T+3 with `rsp_data`=0, `rsp_err`=1, `rsp_z`=0. The ALU opcode and operands stay 0 throughout.
- RST asserted in the CAPTURE cycle of an op=5 (a=1, b=3) → no `rsp*_valid`, all outputs at reset values, and `prio`=0 afterwards.
- Preload is not possible, so run 65536 ops → `op_count` wraps to 0 on the 65536th response.
